// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter sharing one DDR subsystem command/data port between NREQ burst requesters.
// Grant is combinational in IDLE; write beats pass straight through; read beats return one cycle later.
module ddr_cmd_arbiter #(
   parameter int NREQ      = 2,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     req_we,
   input  logic [NREQ*32-1:0]  req_addr,
   output logic [NREQ-1:0]     gnt,
   input  logic [NREQ*32-1:0]  wr_data,
   input  logic [NREQ*4-1:0]   wr_strb,
   input  logic [NREQ-1:0]     wr_valid,
   output logic [NREQ-1:0]     wr_ready,
   output logic [31:0]         rd_data,
   output logic [NREQ-1:0]     rd_valid,
   output logic [NREQ-1:0]     done,
   output logic                err,
   output logic [2:0]          icmd,
   output logic [31:0]         iaddr,
   output logic [31:0]         data_in,
   output logic [3:0]          dmsel,
   output logic                datain_valid,
   input  logic                busy,
   input  logic [31:0]         dataout,
   input  logic                dataout_valid
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d, ptr_q, ptr_d, pick, cand;
   logic            we_q, we_d, err_q, err_d, found;
   logic [31:0]     addr_q, addr_d, rd_data_q, rd_data_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [TW-1:0]   to_q, to_d;
   logic [NREQ-1:0] rd_valid_q, rd_valid_d, own_oh, pick_oh;
   logic            wr_xfer, grant;

   // Search starts at the pointer left by the previous burst's DONE, wrapping.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         cand = OW'((int'(ptr_q) + i) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign own_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
   assign pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << pick;
   assign wr_xfer = (state_q == S_WDATA) && wr_valid[owner_q];
   assign grant   = (state_q == S_IDLE) && ARESETn && !busy && found;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      we_d       = we_q;
      addr_d     = addr_q;
      err_d      = err_q;
      beat_d     = beat_q;
      to_d       = to_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = '0;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               owner_d = pick;
               we_d    = req_we[pick];
               addr_d  = req_addr[pick*32 +: 32];
               err_d   = 1'b0;
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            beat_d  = '0;
            to_d    = '0;
            state_d = we_q ? S_WDATA : S_RDATA;
         end
         S_WDATA: begin
            if (wr_xfer) begin
               if (beat_q == BW'(BURST_LEN - 1)) state_d = S_DONE;
               else                              beat_d  = beat_q + 1'b1;
            end
         end
         S_RDATA: begin
            if (dataout_valid) begin
               rd_data_d  = dataout;
               rd_valid_d = own_oh;
               to_d       = '0;
               if (beat_q == BW'(BURST_LEN - 1)) state_d = S_DONE;
               else                              beat_d  = beat_q + 1'b1;
            end else if (to_q == TW'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th consecutive beat-less cycle.
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         S_DONE: begin
            ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         ptr_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         err_q      <= 1'b0;
         beat_q     <= '0;
         to_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
         beat_q     <= beat_d;
         to_q       <= to_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign gnt          = grant ? pick_oh : '0;
   assign wr_ready     = (state_q == S_WDATA) ? own_oh : '0;
   assign datain_valid = wr_xfer;
   assign data_in      = wr_xfer ? wr_data[owner_q*32 +: 32] : '0;
   assign dmsel        = wr_xfer ? wr_strb[owner_q*4 +: 4] : '0;
   assign icmd         = (state_q == S_CMD) ? (we_q ? 3'd1 : 3'd0) : 3'd4;
   assign iaddr        = (state_q == S_CMD) ? addr_q : '0;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign done         = (state_q == S_DONE) ? own_oh : '0;
   assign err          = (state_q == S_DONE) && err_q;
endmodule

// File: doc/ddr_cmd_arbiter.md
Name: ddr_cmd_arbiter

Overview:
- Round-robin scheduler that shares one ddr_memory_subsystem command/data port between NREQ requesters, e.g. the AXI slave bridge and a DMA/refresh-test engine.
- Accepts one fixed-length burst request at a time and drives the command on icmd/iaddr.
- Sequences write beats into data_in/dmsel, steers returned read beats back to the owning requester, and signals completion or timeout.

Parameters:
NREQ, 2, number of requesters (2..4)
BURST_LEN, 4, beats per burst, 32 bits each
TIMEOUT, 64, max cycles waiting for a read beat before aborting

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESETn  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request, held until gnt
req_we  input  NREQ  1=write burst, 0=read burst
req_addr  input  NREQ*32  start address, slice k belongs to requester k
gnt  output  NREQ  one-cycle grant pulse; address/we sampled this cycle
wr_data  input  NREQ*32  write beat data
wr_strb  input  NREQ*4  write byte enables
wr_valid  input  NREQ  write beat valid
wr_ready  output  NREQ  write beat ready (owner only)
rd_data  output  32  read beat data, shared
rd_valid  output  NREQ  read beat valid, owner bit only, no backpressure
done  output  NREQ  one-cycle burst-complete pulse
err  output  1  qualifies done: 1 = read timeout abort
icmd  output  3  to subsystem: 1=write, 0=read, 4=NOP
iaddr  output  32  to subsystem address
data_in  output  32  to subsystem write data
dmsel  output  4  to subsystem byte mask
datain_valid  output  1  to subsystem write beat strobe
busy  input  1  subsystem busy
dataout  input  32  subsystem read data
dataout_valid  input  1  subsystem read beat strobe

Behaviour:
- Reset values: all outputs 0 except icmd=4; state=IDLE; rr pointer=0; beat and timeout counters=0.
- Reset asserted mid-burst aborts immediately with no done pulse.
- IDLE:
  - icmd=4.
  - If !busy and |req: select the first requester with req set, searching from (last_owner+1) mod NREQ upward with wrap.
  - Latch owner, req_we[owner] and req_addr[owner]; pulse gnt[owner] this cycle; go to CMD.
  - If busy=1, no grant is made regardless of req.
- CMD (exactly 1 cycle):
  - icmd = we ? 1 : 0; iaddr = latched address.
  - Next state WDATA if we, else RDATA; beat counter cleared.
- Outside CMD: icmd=4 and iaddr=0.
- WDATA:
  - wr_ready[owner]=1; all other wr_ready bits 0.
  - Beat transfer when wr_valid[owner] & wr_ready[owner]. In that same cycle, combinationally: datain_valid=1, data_in=wr_data slice, dmsel=wr_strb slice.
  - With no transfer: datain_valid=0, data_in=0, dmsel=0.
  - Stalls indefinitely while wr_valid=0.
  - Transfer on beat BURST_LEN-1 -> DONE.
- RDATA:
  - Each dataout_valid cycle registers dataout into rd_data and pulses rd_valid[owner] on the next cycle (1-cycle latency); increments the beat counter and clears the timeout counter.
  - BURST_LEN-th beat -> DONE.
  - dataout_valid seen in any other state is ignored.
  - Timeout counter increments on each RDATA cycle without a beat; at TIMEOUT -> DONE with err=1.
- DONE (1 cycle):
  - done[owner]=1; err=1 only on timeout, else 0.
  - last_owner=owner; go to IDLE.
- A new grant cannot occur earlier than the cycle after DONE.
- Owner deasserting req mid-burst has no effect; the burst completes.
- Non-owner bits of gnt, wr_ready, rd_valid and done are always 0.
- Burst wrap/increment of the address is the subsystem's job; the arbiter issues the start address only.

Test Plan:
- Single write: reset; req[0]=1, we=1, addr=0x100; 4 beats 0x11111111..0x44444444, strb=0xF -> gnt[0] pulse; icmd=1 with iaddr=0x100 for 1 cycle; 4 datain_valid cycles with matching data; done[0]=1, err=0.
- Single read: req[1] read at 0x200; subsystem returns 4 dataout_valid beats A,B,C,D -> rd_valid[1] pulses one cycle after each beat with rd_data=A..D; done[1]; rd_valid[0] never asserts.
- Fairness: req=2'b11 held continuously -> grants alternate 0,1,0,1 over 4 bursts; first grant is requester 0 after reset.
- Busy gating: busy=1 while req[0]=1 -> no gnt and icmd=4; busy falls -> gnt on that cycle.
- Write stall and timeout: wr_valid low for 10 cycles mid-burst -> datain_valid=0 and no done. Read with only 2 beats returned -> done[owner] and err=1 exactly 64 cycles after the last beat.
- Reset mid-burst: ARESETn low during the 3rd write beat -> all outputs at reset values and icmd=4 immediately. After release, a new req is granted and completes normally.
